if_fetch_ctrl: RTL

//  Instruction-fetch controller for the IF stage. Owns the PC and ROM enable.

---
 rtl/if_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller for the IF stage. It owns the PC, issues ROM
// reads over a ce/ack handshake, buffers returned words in a 2-entry FIFO and
// presents the FIFO head to IF/ID with a valid/ready handshake. A flush or
// taken branch redirects fetch and discards everything buffered or in flight.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush_i           flush redirect request (wins over branch)
//   flush_pc_i        flush target
//   branch_flag_i     taken-branch redirect request
//   branch_target_i   branch target
//   rom_ce_o          ROM request, held until rom_ack_i
//   rom_addr_o        ROM word address, held until rom_ack_i
//   rom_ack_i         ROM data valid this cycle
//   rom_data_i        ROM read data
//   inst_valid_o      FIFO head valid
//   inst_o            FIFO head instruction
//   inst_pc_o         PC of FIFO head
//   inst_ready_i      IF/ID accepts the head
//
// Optional build macro IF_FETCH_PERF_EN adds two counters:
//   perf_fetch_o      words pushed into the FIFO
//   perf_drop_o       words discarded (drain acks, same-cycle redirect acks,
//                     FIFO entries flushed)
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_drop_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              rom_ce_d;

    // Tail slot of the FIFO; the head slot is the inst_* output registers.
    logic              tail_valid_q;
    logic [DATA_W-1:0] tail_data_q;
    logic [ADDR_W-1:0] tail_pc_q;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              ack_req;
    logic              push;
    logic              pop;
    logic [1:0]        count_q;
    logic [1:0]        count_post;

    assign redirect = flush_i | branch_flag_i;
    assign target   = flush_i ? flush_pc_i : branch_target_i;

    // Only an ack to a live REQ carries a word worth keeping; a redirect in the
    // same cycle kills it, and a redirect also blocks the pop.
    assign ack_req  = (state_q == S_REQ) && rom_ack_i;
    assign push     = ack_req && !redirect;
    assign pop      = inst_valid_o && inst_ready_i && !redirect;

    assign count_q    = {1'b0, inst_valid_o} + {1'b0, tail_valid_q};
    assign count_post = count_q + {1'b0, push} - {1'b0, pop};

    // -------------------------------------------------------------------------
    // Next-state / next-PC
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) pc_d = target;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d    = target;
                    // Without an ack the old request is still owed a response,
                    // which must be swallowed before the new address goes out.
                    state_d = rom_ack_i ? S_REQ : S_DRAIN;
                end else if (rom_ack_i) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (count_post == 2'd2) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (pop) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = target;
                end else if (rom_ack_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rom_ce_d   = (state_d == S_REQ) || (state_d == S_DRAIN);
        // While draining, the stale address must stay on the bus until acked.
        rom_addr_d = (state_d == S_DRAIN) ? rom_addr_o : pc_d;
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VECTOR;
            rom_ce_o   <= 1'b0;
            rom_addr_o <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_ce_o   <= rom_ce_d;
            rom_addr_o <= rom_addr_d;
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry FIFO: head slot drives the outputs, tail slot shifts into it.
    // -------------------------------------------------------------------------
    // NOTE: the head data/PC registers are outputs with defined reset values,
    // so the whole buffer is reset; with only two entries this costs nothing
    // and keeps the tail slot free of X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            tail_valid_q <= 1'b0;
            tail_data_q  <= '0;
            tail_pc_q    <= '0;
        end else if (redirect) begin
            inst_valid_o <= 1'b0;
            tail_valid_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (!inst_valid_o) begin
                        inst_valid_o <= 1'b1;
                        inst_o       <= rom_data_i;
                        inst_pc_o    <= pc_q;
                    end else begin
                        tail_valid_q <= 1'b1;
                        tail_data_q  <= rom_data_i;
                        tail_pc_q    <= pc_q;
                    end
                end
                2'b01: begin
                    inst_valid_o <= tail_valid_q;
                    inst_o       <= tail_data_q;
                    inst_pc_o    <= tail_pc_q;
                    tail_valid_q <= 1'b0;
                end
                2'b11: begin
                    if (tail_valid_q) begin
                        inst_o      <= tail_data_q;
                        inst_pc_o   <= tail_pc_q;
                        tail_data_q <= rom_data_i;
                        tail_pc_q   <= pc_q;
                    end else begin
                        inst_o    <= rom_data_i;
                        inst_pc_o <= pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] drop_inc;

    always_comb begin
        drop_inc = 32'd0;
        if (redirect)                         drop_inc = drop_inc + 32'(count_q);
        if (ack_req && redirect)              drop_inc = drop_inc + 32'd1;
        if ((state_q == S_DRAIN) && rom_ack_i) drop_inc = drop_inc + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_o <= 32'd0;
            perf_drop_o  <= 32'd0;
        end else begin
            perf_fetch_o <= perf_fetch_o + 32'(push);
            perf_drop_o  <= perf_drop_o + drop_inc;
        end
    end
`endif

endmodule
